// File: rtl/obstacle_line_scheduler_if.sv
// Bus bundle between the obstacle line scheduler and its neighbours. The bundle carries the
// line-start request, the obstacle table read port, the pixel stream and the status pulses.
interface obstacle_line_scheduler_if #(
  parameter int unsigned ScreenWidth   = 10,
  parameter int unsigned BlockLenWidth = 4,
  parameter int unsigned ObsIdxWidth   = 4
);
  logic                                   line_start;
  logic [ScreenWidth-1:0]                 next_y;
  logic                                   tbl_rd_en;
  logic [ObsIdxWidth-1:0]                 tbl_addr;
  logic [2*ScreenWidth+BlockLenWidth-1:0] tbl_rd_data;
  logic                                   video_on;
  logic [ScreenWidth-1:0]                 pixel_x;
  logic [ScreenWidth-1:0]                 pixel_y;
  logic                                   obstacle_on;
  logic [ScreenWidth-1:0]                 obstacle_x_rom;
  logic [ScreenWidth-1:0]                 obstacle_y_rom;
  logic                                   scan_busy;
  logic                                   slot_overflow;
  logic                                   scan_late;

  // Upstream side: video timing, table memory and the consumer of the pixel results.
  modport master (
    output line_start, next_y, tbl_rd_data, video_on, pixel_x, pixel_y,
    input  tbl_rd_en, tbl_addr, obstacle_on, obstacle_x_rom, obstacle_y_rom,
    input  scan_busy, slot_overflow, scan_late
  );

  // Scheduler side.
  modport slave (
    input  line_start, next_y, tbl_rd_data, video_on, pixel_x, pixel_y,
    output tbl_rd_en, tbl_addr, obstacle_on, obstacle_x_rom, obstacle_y_rom,
    output scan_busy, slot_overflow, scan_late
  );
endinterface

// File: rtl/obstacle_line_scheduler.sv
// Per-scanline obstacle scheduler. On line_start the whole obstacle table is scanned and up to
// SlotNum entries that intersect the next line go into a shadow slot bank, which becomes the
// active bank at commit. The pixel path reads only the active bank.
module obstacle_line_scheduler #(
  parameter int unsigned ScreenWidth   = 10,
  parameter int unsigned ObstacleWidth = 10,
  parameter int unsigned BlockLenWidth = 4,
  parameter int unsigned ObsNum        = 16,
  parameter int unsigned ObsIdxWidth   = 4,
  parameter int unsigned SlotNum       = 4
) (
  input logic                     sys_clk,
  input logic                     sys_rst,
  obstacle_line_scheduler_if.slave bus_io
);
  localparam int unsigned WideW    = ScreenWidth + 1;
  localparam int unsigned CntW     = $clog2(SlotNum + 1);
  localparam int unsigned SlotIdxW = (SlotNum > 1) ? $clog2(SlotNum) : 1;

  typedef enum logic [1:0] {StIdle, StScan, StDrain, StCommit} state_e;

  state_e                 state_q, state_d;
  logic [ObsIdxWidth-1:0] idx_q, idx_d;
  logic [ScreenWidth-1:0] ny_q, ny_d;
  logic                   ptr_q, ptr_d;
  logic                   eval_q, eval_d;
  logic                   ovf_q, ovf_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   clr_shadow, slot_we, rd_en, ovf_pulse;
  logic [ObsIdxWidth-1:0] rd_addr;

  // Two slot banks, indexed by bank then slot.
  logic                   bank_valid_q [2][SlotNum];
  logic [ScreenWidth-1:0] bank_x_q     [2][SlotNum];
  logic [ScreenWidth-1:0] bank_row_q   [2][SlotNum];
  logic [WideW-1:0]       bank_w_q     [2][SlotNum];

  // Returned table entry and its hit test against the latched line.
  logic [ScreenWidth-1:0]   ent_x, ent_y;
  logic [BlockLenWidth-1:0] ent_len;
  logic [WideW-1:0]         ent_y_end, ent_width;
  logic                     hit;

  assign {ent_x, ent_y, ent_len} = bus_io.tbl_rd_data;
  assign ent_y_end = {1'b0, ent_y} + WideW'(2 * ObstacleWidth);
  assign ent_width = WideW'(ent_len) * WideW'(ObstacleWidth);
  assign hit = eval_q && (ent_len != '0) && (ent_y <= ny_q) && ({1'b0, ny_q} < ent_y_end);

  // Scan FSM and bookkeeping state register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      ny_q    <= '0;
      ptr_q   <= 1'b0;
      eval_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ny_q    <= ny_d;
      ptr_q   <= ptr_d;
      eval_q  <= eval_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: table reads, slot fill, commit, and restart on line_start.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ny_d       = ny_q;
    ptr_d      = ptr_q;
    eval_d     = 1'b0;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    clr_shadow = 1'b0;
    slot_we    = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = '0;
    ovf_pulse  = 1'b0;
    case (state_q)
      StIdle: ;
      StScan: begin
        rd_en   = 1'b1;
        rd_addr = idx_q;
        eval_d  = 1'b1;
        idx_d   = idx_q + 1'b1;
        if (idx_q == ObsIdxWidth'(ObsNum - 1)) state_d = StDrain;
      end
      StDrain: state_d = StCommit;
      StCommit: begin
        ptr_d     = ~ptr_q;
        ovf_pulse = ovf_q;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (hit) begin
      if (cnt_q < CntW'(SlotNum)) begin
        slot_we = 1'b1;
        cnt_d   = cnt_q + 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
    // A new line always restarts the scan; a commit in progress still toggles the pointer.
    if (bus_io.line_start) begin
      ny_d       = bus_io.next_y;
      clr_shadow = 1'b1;
      slot_we    = 1'b0;
      cnt_d      = '0;
      ovf_d      = 1'b0;
      idx_d      = '0;
      eval_d     = 1'b0;
      state_d    = StScan;
    end
  end

  // Slot banks: clear the next shadow bank on scan start, fill it in table order.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int s = 0; s < SlotNum; s++) bank_valid_q[b][s] <= 1'b0;
      end
    end else begin
      if (clr_shadow) begin
        for (int s = 0; s < SlotNum; s++) bank_valid_q[~ptr_d][s] <= 1'b0;
      end
      if (slot_we) begin
        bank_valid_q[~ptr_q][cnt_q[SlotIdxW-1:0]] <= 1'b1;
        bank_x_q[~ptr_q][cnt_q[SlotIdxW-1:0]]     <= ent_x;
        bank_row_q[~ptr_q][cnt_q[SlotIdxW-1:0]]   <= ny_q - ent_y;
        bank_w_q[~ptr_q][cnt_q[SlotIdxW-1:0]]     <= ent_width;
      end
    end
  end

  // Pixel path: lowest-numbered covering slot of the active bank wins.
  logic                   cover_any, on_d, on_q;
  logic [ScreenWidth-1:0] sel_x, sel_row, xrom_d, xrom_q, yrom_d, yrom_q;

  always_comb begin
    cover_any = 1'b0;
    sel_x     = '0;
    sel_row   = '0;
    for (int s = SlotNum - 1; s >= 0; s--) begin
      if (bank_valid_q[ptr_q][s] && (bus_io.pixel_x >= bank_x_q[ptr_q][s]) &&
          ({1'b0, bus_io.pixel_x} < ({1'b0, bank_x_q[ptr_q][s]} + bank_w_q[ptr_q][s]))) begin
        cover_any = 1'b1;
        sel_x     = bank_x_q[ptr_q][s];
        sel_row   = bank_row_q[ptr_q][s];
      end
    end
    on_d   = bus_io.video_on & cover_any;
    xrom_d = on_d ? (bus_io.pixel_x - sel_x) : '0;
    yrom_d = on_d ? sel_row : '0;
  end

  // Registered pixel outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      on_q   <= 1'b0;
      xrom_q <= '0;
      yrom_q <= '0;
    end else begin
      on_q   <= on_d;
      xrom_q <= xrom_d;
      yrom_q <= yrom_d;
    end
  end

  assign bus_io.tbl_rd_en      = rd_en;
  assign bus_io.tbl_addr       = rd_addr;
  assign bus_io.obstacle_on    = on_q;
  assign bus_io.obstacle_x_rom = xrom_q;
  assign bus_io.obstacle_y_rom = yrom_q;
  assign bus_io.scan_busy      = (state_q != StIdle);
  assign bus_io.slot_overflow  = ovf_pulse;
  assign bus_io.scan_late      = bus_io.line_start & (state_q != StIdle);
endmodule

// File: tb/tb_obstacle_line_scheduler.sv
// Self-checking bench for obstacle_line_scheduler: table-driven pixel vectors with a
// scoreboard queue, plus hand-written sequences for abort, commit overlap and reset.
module tb_obstacle_line_scheduler;
  localparam int ObsNum  = 16;
  localparam int ScanLen = ObsNum + 3;  // busy from cycle 1 through commit at cycle ObsNum+2

  logic sys_clk = 1'b0;
  logic sys_rst;
  always #5 sys_clk = ~sys_clk;

  obstacle_line_scheduler_if bus ();

  obstacle_line_scheduler dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus_io  (bus)
  );

  // Obstacle table memory, one-cycle read latency.
  logic [23:0] tbl [ObsNum];
  always @(posedge sys_clk) if (bus.tbl_rd_en) bus.tbl_rd_data <= tbl[bus.tbl_addr];

  typedef struct {
    int px; bit von; bit on; int x; int y;
  } vec_t;

  typedef struct packed {
    logic on; logic [9:0] x; logic [9:0] y;
  } exp_t;

  vec_t vecs[$];
  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [23:0] ent(input int x, input int y, input int len);
    logic [9:0] xx, yy;
    logic [3:0] ll;
    xx = 10'(x); yy = 10'(y); ll = 4'(len);
    return {xx, yy, ll};
  endfunction

  task automatic clear_table();
    for (int i = 0; i < ObsNum; i++) tbl[i] = '0;
  endtask

  // One pixel per clock: drive, push the expectation, compare after the capturing edge.
  task automatic pix(input int px, input bit von, input bit on, input int x, input int y);
    exp_t e, a;
    @(negedge sys_clk);
    bus.pixel_x  = 10'(px);
    bus.video_on = von;
    e.on = on; e.x = 10'(x); e.y = 10'(y);
    expq.push_back(e);
    @(posedge sys_clk);
    #1;
    a = {bus.obstacle_on, bus.obstacle_x_rom, bus.obstacle_y_rom};
    if (expq.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = expq.pop_front();
      check($sformatf("pix_%0d", px), 32'(a), 32'(e));
    end
    bus.video_on = 1'b0;
  endtask

  task automatic run_vecs();
    foreach (vecs[i]) pix(vecs[i].px, vecs[i].von, vecs[i].on, vecs[i].x, vecs[i].y);
    vecs.delete();
  endtask

  // Called in cycle 1 of a scan; returns the cycle busy drops and overflow pulse info.
  task automatic wait_idle(output int n, output int ovf, output int ovf_cyc);
    n = 1; ovf = 0; ovf_cyc = -1;
    while (bus.scan_busy && n < 100) begin
      if (bus.slot_overflow) begin ovf++; ovf_cyc = n; end
      @(negedge sys_clk);
      n++;
    end
  endtask

  task automatic do_scan(input int ny, output int n, output int ovf, output int ovf_cyc);
    @(negedge sys_clk);
    bus.line_start = 1'b1;
    bus.next_y     = 10'(ny);
    bus.pixel_y    = 10'(ny);
    @(negedge sys_clk);
    bus.line_start = 1'b0;
    wait_idle(n, ovf, ovf_cyc);
  endtask

  int n, ovf, ovf_cyc;

  initial begin
    sys_rst = 1'b1;
    bus.line_start = 1'b0; bus.next_y = '0; bus.video_on = 1'b0;
    bus.pixel_x = '0; bus.pixel_y = '0; bus.tbl_rd_data = '0;
    clear_table();
    repeat (3) @(negedge sys_clk);
    check("rst_on",   32'(bus.obstacle_on), 0);
    check("rst_xrom", 32'(bus.obstacle_x_rom), 0);
    check("rst_yrom", 32'(bus.obstacle_y_rom), 0);
    check("rst_busy", 32'(bus.scan_busy), 0);
    check("rst_ovf",  32'(bus.slot_overflow), 0);
    check("rst_rden", 32'(bus.tbl_rd_en), 0);
    sys_rst = 1'b0;

    // Single two-block obstacle; checks scan length and the full horizontal span.
    tbl[0] = ent(100, 50, 2);
    do_scan(55, n, ovf, ovf_cyc);
    check("t1_scan_len", 32'(n), 32'(ScanLen));
    check("t1_no_ovf",   32'(ovf), 0);
    for (int px = 99; px <= 121; px++) begin
      if (px >= 100 && px <= 119) vecs.push_back('{px, 1'b1, 1'b1, px - 100, 5});
      else                        vecs.push_back('{px, 1'b1, 1'b0, 0, 0});
    end
    vecs.push_back('{110, 1'b0, 1'b0, 0, 0});
    run_vecs();

    // Vertical boundaries.
    do_scan(49, n, ovf, ovf_cyc);
    vecs.push_back('{100, 1'b1, 1'b0, 0, 0});
    vecs.push_back('{110, 1'b1, 1'b0, 0, 0});
    run_vecs();
    do_scan(70, n, ovf, ovf_cyc);
    vecs.push_back('{105, 1'b1, 1'b0, 0, 0});
    run_vecs();
    do_scan(69, n, ovf, ovf_cyc);
    vecs.push_back('{105, 1'b1, 1'b1, 5, 19});
    run_vecs();

    // Six hits: first four kept in table order, one overflow pulse at commit.
    clear_table();
    for (int i = 0; i < 6; i++) tbl[i] = ent(50 * i + 10, 0, 1);
    do_scan(10, n, ovf, ovf_cyc);
    check("t3_ovf_count", 32'(ovf), 1);
    check("t3_ovf_cycle", 32'(ovf_cyc), 32'(ObsNum + 2));
    vecs.push_back('{15,  1'b1, 1'b1, 5, 10});
    vecs.push_back('{165, 1'b1, 1'b1, 5, 10});
    vecs.push_back('{215, 1'b1, 1'b0, 0, 0});
    vecs.push_back('{265, 1'b1, 1'b0, 0, 0});
    run_vecs();

    // Overlapping entries: lowest slot wins.
    clear_table();
    tbl[0] = ent(40, 0, 1);
    tbl[1] = ent(45, 0, 1);
    do_scan(3, n, ovf, ovf_cyc);
    vecs.push_back('{47, 1'b1, 1'b1, 7, 3});
    vecs.push_back('{54, 1'b1, 1'b1, 9, 3});
    vecs.push_back('{55, 1'b1, 1'b0, 0, 0});
    run_vecs();

    // Abort: second line_start five cycles into a scan.
    clear_table();
    tbl[0] = ent(300, 0, 1);
    @(negedge sys_clk);
    bus.line_start = 1'b1; bus.next_y = 10'd5;
    @(negedge sys_clk);
    bus.line_start = 1'b0;
    repeat (4) @(negedge sys_clk);
    bus.line_start = 1'b1; bus.next_y = 10'd6;
    #1;
    check("t5_scan_late", 32'(bus.scan_late), 1);
    @(negedge sys_clk);
    bus.line_start = 1'b0;
    #1;
    check("t5_late_pulse", 32'(bus.scan_late), 0);
    vecs.push_back('{47,  1'b1, 1'b1, 7, 3});
    vecs.push_back('{305, 1'b1, 1'b0, 0, 0});
    run_vecs();
    @(negedge sys_clk);
    wait_idle(n, ovf, ovf_cyc);
    check("t5_restart_len", 32'(n + 3), 32'(ScanLen));
    vecs.push_back('{305, 1'b1, 1'b1, 5, 6});
    vecs.push_back('{47,  1'b1, 1'b0, 0, 0});
    run_vecs();

    // line_start coincident with commit: first bank still goes live, then the new scan.
    clear_table();
    tbl[0] = ent(500, 0, 1);
    @(negedge sys_clk);
    bus.line_start = 1'b1; bus.next_y = 10'd2;
    @(negedge sys_clk);
    bus.line_start = 1'b0;
    repeat (ObsNum + 1) @(negedge sys_clk);
    check("t7_commit_busy", 32'(bus.scan_busy), 1);
    bus.line_start = 1'b1; bus.next_y = 10'd4;
    #1;
    check("t7_late_at_commit_busy", 32'(bus.scan_busy), 1);
    @(negedge sys_clk);
    bus.line_start = 1'b0;
    #1;
    check("t7_rescan_busy", 32'(bus.scan_busy), 1);
    vecs.push_back('{505, 1'b1, 1'b1, 5, 2});
    run_vecs();
    @(negedge sys_clk);
    wait_idle(n, ovf, ovf_cyc);
    vecs.push_back('{505, 1'b1, 1'b1, 5, 4});
    run_vecs();

    // No wrap near the bottom of the coordinate range, then reset mid-scan.
    clear_table();
    tbl[0] = ent(200, 1015, 1);
    do_scan(1020, n, ovf, ovf_cyc);
    vecs.push_back('{205, 1'b1, 1'b1, 5, 5});
    run_vecs();
    @(negedge sys_clk);
    bus.line_start = 1'b1; bus.next_y = 10'd1020;
    bus.video_on = 1'b1; bus.pixel_x = 10'd205;
    @(negedge sys_clk);
    bus.line_start = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("t6_pre_rst_on", 32'(bus.obstacle_on), 1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("t6_rst_busy", 32'(bus.scan_busy), 0);
    check("t6_rst_on",   32'(bus.obstacle_on), 0);
    check("t6_rst_xrom", 32'(bus.obstacle_x_rom), 0);
    check("t6_rst_yrom", 32'(bus.obstacle_y_rom), 0);
    check("t6_rst_rden", 32'(bus.tbl_rd_en), 0);
    sys_rst = 1'b0;
    bus.video_on = 1'b0;
    vecs.push_back('{205, 1'b1, 1'b0, 0, 0});
    run_vecs();

    check("scoreboard_drained", 32'(expq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
